// File: rtl/lc4_wb_regfile.sv
// LC4 write-back stage: a 2-entry in-order result buffer that retires into an
// 8x16 register file and the NZP register, with forwarded operand reads.
module lc4_wb_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gwe,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [2:0]        i_wb_rd,
  input  logic              i_wb_regwe,
  input  logic              i_wb_nzpwe,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_retire_en,
  input  logic [2:0]        i_rs_sel,
  input  logic [2:0]        i_rt_sel,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [2:0]        o_nzp,
  output logic [1:0]        o_count
);

  typedef struct packed {
    logic [2:0]        rd;
    logic              regwe;
    logic              nzpwe;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Entry 0 is always the head (oldest); entry 1 is valid only when count is 2.
  wb_rec_t           ent_q [DEPTH];
  wb_rec_t           ent_d [DEPTH];
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  logic [2:0]        nzp_q, nzp_d;
  logic              accept, retire, tail_idx;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])  return 3'b100;
    else if (d == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [2:0] sel);
    logic [DATA_W-1:0] v;
    v = rf_q[sel];
    if (count_q != 2'd0 && ent_q[0].regwe && ent_q[0].rd == sel) v = ent_q[0].data;
    if (count_q == FULL && ent_q[1].regwe && ent_q[1].rd == sel) v = ent_q[1].data;
    return v;
  endfunction

  // Handshake: a record transfers at a rising edge where i_wb_valid and
  // o_wb_ready are both high; ready depends only on gwe and registered count.
  assign o_wb_ready = gwe && (count_q < FULL);
  assign o_count    = count_q;

  always_comb begin
    o_rs_data = read_port(i_rs_sel);
    o_rt_data = read_port(i_rt_sel);
    o_nzp     = nzp_q;
    if (count_q == FULL && ent_q[1].nzpwe)          o_nzp = nzp_of(ent_q[1].data);
    else if (count_q != 2'd0 && ent_q[0].nzpwe)     o_nzp = nzp_of(ent_q[0].data);
  end

  always_comb begin
    accept   = gwe && i_wb_valid && o_wb_ready;
    retire   = gwe && i_retire_en && (count_q != 2'd0);
    tail_idx = count_q[0] && !retire;
    ent_d    = ent_q;
    rf_d     = rf_q;
    nzp_d    = nzp_q;
    count_d  = count_q;
    if (retire) begin
      if (ent_q[0].regwe) rf_d[ent_q[0].rd] = ent_q[0].data;
      if (ent_q[0].nzpwe) nzp_d = nzp_of(ent_q[0].data);
      ent_d[0] = ent_q[1];
    end
    if (accept) begin
      ent_d[tail_idx] = '{rd: i_wb_rd, regwe: i_wb_regwe, nzpwe: i_wb_nzpwe, data: i_wb_data};
    end
    if (accept && !retire)      count_d = count_q + 2'd1;
    else if (!accept && retire) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      nzp_q   <= 3'b010;
      count_q <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      rf_q    <= rf_d;
      nzp_q   <= nzp_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_lc4_wb_regfile.sv
// Bench for lc4_wb_regfile: directed scenarios plus random traffic, checked
// against a queue-based model of pending records and architectural state.
module tb_lc4_wb_regfile;

  localparam int W = 21;  // record packing: {rd[20:18], regwe[17], nzpwe[16], data[15:0]}

  logic        clk = 1'b0;
  logic        rst_n, gwe, i_wb_valid, i_wb_regwe, i_wb_nzpwe, i_retire_en;
  logic [2:0]  i_wb_rd, i_rs_sel, i_rt_sel;
  logic [15:0] i_wb_data;
  logic        o_wb_ready;
  logic [15:0] o_rs_data, o_rt_data;
  logic [2:0]  o_nzp;
  logic [1:0]  o_count;

  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;
  logic        acc_fire = 1'b0;
  logic        ret_fire = 1'b0;
  logic [W-1:0] offer;

  lc4_wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .gwe(gwe),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
    .i_wb_rd(i_wb_rd), .i_wb_regwe(i_wb_regwe), .i_wb_nzpwe(i_wb_nzpwe),
    .i_wb_data(i_wb_data), .i_retire_en(i_retire_en),
    .i_rs_sel(i_rs_sel), .i_rt_sel(i_rt_sel),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_nzp(o_nzp), .o_count(o_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] ref_read(input logic [2:0] sel);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][17] && exp_q[i][20:18] == sel) return exp_q[i][15:0];
    return m_reg[sel];
  endfunction

  function automatic logic [2:0] ref_nzp_view();
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][16]) return ref_nzp(exp_q[i][15:0]);
    return m_nzp;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_nzp    = 3'b010;
    acc_fire = 1'b0;
    ret_fire = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: retire pops the head record in order and applies it to the
  // architectural model; accept appends the offered record.
  always @(posedge clk) begin
    if (rst_n) begin
      if (ret_fire) begin
        logic [W-1:0] rec;
        rec = exp_q.pop_front();
        if (rec[17]) m_reg[rec[20:18]] = rec[15:0];
        if (rec[16]) m_nzp = ref_nzp(rec[15:0]);
      end
      if (acc_fire) exp_q.push_back(offer);
    end
  end

  // Monitor: compares every visible output against the model each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", 16'(o_wb_ready), 16'(gwe && exp_q.size() < 2));
      check("count", 16'(o_count), 16'(exp_q.size()));
      check("rs_data", o_rs_data, ref_read(i_rs_sel));
      check("rt_data", o_rt_data, ref_read(i_rt_sel));
      check("nzp", 16'(o_nzp), 16'(ref_nzp_view()));
    end
  end

  task automatic step(input logic g, input logic v, input logic [2:0] rd,
                      input logic regwe, input logic nzpwe, input logic [15:0] d,
                      input logic ret, input logic [2:0] rs, input logic [2:0] rt);
    gwe = g; i_wb_valid = v; i_wb_rd = rd; i_wb_regwe = regwe;
    i_wb_nzpwe = nzpwe; i_wb_data = d; i_retire_en = ret;
    i_rs_sel = rs; i_rt_sel = rt;
    offer    = {rd, regwe, nzpwe, d};
    acc_fire = rst_n && g && v && (exp_q.size() < 2);
    ret_fire = rst_n && g && ret && (exp_q.size() > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0, 3'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd3, 3'd5);
    check("rst_ready_gwe0", 16'(o_wb_ready), 16'd0);
    check("rst_count", 16'(o_count), 16'd0);
    check("rst_nzp", 16'(o_nzp), 16'h0002);
    check("rst_rs", o_rs_data, 16'h0000);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd3, 3'd5);
    check("rst_ready_gwe1", 16'(o_wb_ready), 16'd1);

    // Minimum latency: accept then retire on the next edge.
    step(1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd3, 3'd0);
    check("t1_fwd_rs", o_rs_data, 16'h1234);
    check("t1_fwd_nzp", 16'(o_nzp), 16'h0001);
    check("t1_count1", 16'(o_count), 16'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 3'd0);
    check("t1_r3", o_rs_data, 16'h1234);
    check("t1_nzp", 16'(o_nzp), 16'h0001);
    check("t1_count0", 16'(o_count), 16'd0);

    // Two pending writes to the same register: youngest wins.
    step(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 16'hFFFF, 1'b0, 3'd3, 3'd2);
    step(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 16'h0000, 1'b0, 3'd3, 3'd2);
    check("t2_count2", 16'(o_count), 16'd2);
    check("t2_ready0", 16'(o_wb_ready), 16'd0);
    check("t2_rt", o_rt_data, 16'h0000);
    check("t2_nzp", 16'(o_nzp), 16'h0002);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 3'd2);
    check("t2_rt_after1", o_rt_data, 16'h0000);
    check("t2_nzp_after1", 16'(o_nzp), 16'h0002);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 3'd2);
    check("t2_r2", o_rt_data, 16'h0000);
    check("t2_count0", 16'(o_count), 16'd0);

    // Full buffer with valid and retire held: count runs 2, 1, 1, 1.
    step(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 16'h1111, 1'b0, 3'd1, 3'd4);
    step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 16'h4444, 1'b0, 3'd1, 3'd4);
    check("t3_count2", 16'(o_count), 16'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 16'h2000 + 16'(i), 1'b1, 3'd1, 3'd4);
      check("t3_count1", 16'(o_count), 16'd1);
    end
    drain();

    // gwe low freezes everything, forwarding still visible.
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 16'h0ABC, 1'b0, 3'd5, 3'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 16'h9999, 1'b1, 3'd5, 3'd6);
      check("t4_ready0", 16'(o_wb_ready), 16'd0);
      check("t4_count1", 16'(o_count), 16'd1);
      check("t4_fwd", o_rs_data, 16'h0ABC);
      check("t4_r6", o_rt_data, 16'h0000);
    end
    drain();

    // NZP-only record leaves the register untouched.
    step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0055, 1'b1, 3'd4, 3'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd4, 3'd0);
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 16'h8000, 1'b0, 3'd4, 3'd0);
    check("t5_r4_pend", o_rs_data, 16'h0055);
    check("t5_nzp_pend", 16'(o_nzp), 16'h0004);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd4, 3'd0);
    check("t5_r4_ret", o_rs_data, 16'h0055);
    check("t5_nzp_ret", 16'(o_nzp), 16'h0004);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        default: d = 16'($urandom_range(0, 16'hFFFF));
      endcase
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d,
           1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    drain();
    for (int s = 0; s < 8; s++)
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'(s), 3'(7 - s));

    // Asynchronous reset with two pending records.
    step(1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 16'h6666, 1'b0, 3'd6, 3'd7);
    step(1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 16'h7777, 1'b0, 3'd6, 3'd7);
    check("t6_count2", 16'(o_count), 16'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_count", 16'(o_count), 16'd0);
    check("t6_nzp", 16'(o_nzp), 16'h0002);
    check("t6_rs", o_rs_data, 16'h0000);
    check("t6_rt", o_rt_data, 16'h0000);
    check("t6_ready", 16'(o_wb_ready), 16'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd6, 3'd7);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd6, 3'd7);
    check("t6_r6", o_rs_data, 16'h0000);
    check("t6_r7", o_rt_data, 16'h0000);
    for (int s = 0; s < 8; s++)
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'(s), 3'(7 - s));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc4_wb_regfile.md
Name: lc4_wb_regfile

Overview:
Write-back end of the LC4 datapath. It accepts result records (destination register, data, write enables) from the ALU or other execute sources through a valid/ready handshake. Records are held in a 2-entry in-order buffer, then retired one per cycle into an 8x16 register file and the NZP condition-code register. It supplies the rs/rt operand reads that feed the ALU, forwarding values from pending buffer entries so readers always see the newest accepted value.

Parameters:
DATA_W, 16, register and data width (LC4 fixes this at 16)
DEPTH, 2, write-back buffer entries (fixed at 2; count width 2 bits)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
gwe  in  1  global write enable; when 0, no state changes at all
i_wb_valid  in  1  a write-back record is offered
o_wb_ready  out  1  the block can accept a record this cycle
i_wb_rd  in  3  destination register
i_wb_regwe  in  1  record writes the register file
i_wb_nzpwe  in  1  record updates NZP
i_wb_data  in  16  result value
i_retire_en  in  1  the head record may retire this cycle
i_rs_sel  in  3  read port A select
i_rt_sel  in  3  read port B select
o_rs_data  out  16  read port A data, forwarded
o_rt_data  out  16  read port B data, forwarded
o_nzp  out  3  architectural NZP, forwarded {N,Z,P}
o_count  out  2  number of pending records (0..2)

Behaviour:
- Reset (rst_n low, async): R0..R7 = 16'h0000; NZP = 3'b010; buffer empty; o_count = 0. This gives o_wb_ready = 0 while gwe = 0 and 1 once gwe = 1.
- o_wb_ready = gwe && (count < 2). It depends only on registered state and gwe, with no path from i_wb_valid.
- Accept: at an edge where gwe && i_wb_valid && o_wb_ready, the record {rd, regwe, nzpwe, data} goes to the tail.
- Retire: at an edge where gwe && i_retire_en && count > 0, the head record is applied and popped.
  - If the head's regwe = 1, then R[rd] <= data.
  - If the head's nzpwe = 1, NZP is set from data: data[15] gives 100; data == 0 gives 010; otherwise 001.
- Accept and retire in the same cycle are both legal, including at count = 2 only if ready was high. Because ready is low at count = 2, no accept happens that cycle; retire still proceeds.
- Count update: +1 on accept only, -1 on retire only, unchanged on both or neither.
- Minimum latency: a record accepted at edge N into an empty buffer can retire at edge N+1.
- Records retire strictly in order. Records with regwe = 0 and nzpwe = 0 still occupy a slot and retire normally.
- Reads are combinational. For each port, the priority is:
  1. the youngest pending entry with regwe = 1 and rd == sel;
  2. then the older pending entry with regwe = 1 and rd == sel;
  3. then R[sel].
- The record being offered on i_wb_* in the current cycle is NOT forwarded.
- o_nzp follows the same rule: the NZP derived from the youngest pending entry with nzpwe = 1, otherwise the NZP register.
- R0 is an ordinary writable register (LC4 has no hardwired zero).
- When gwe = 0: no accept, no retire, registers, NZP and buffer hold. Reads and forwarding still operate.
- Reset during operation: pending records are discarded with no partial write, and all state returns to reset values immediately.

Test Plan:
- Reset, then gwe = 1. Offer rd = 3, data = 16'h1234, regwe = 1, nzpwe = 1 with i_retire_en = 1. Required: o_rs_data (sel = 3) = 1234 one cycle after accept via forwarding; after retire R3 = 1234, o_nzp = 001, o_count = 0.
- With i_retire_en = 0, accept R2 <= 16'hFFFF (nzpwe) then R2 <= 16'h0000 (nzpwe). Required: o_count = 2, o_wb_ready = 0, o_rt_data (sel = 2) = 0000, o_nzp = 010. Then release retire: after the first retire, forwarding still gives 0000/010; after the second, R2 = 0000 and count = 0.
- At count = 2 with i_retire_en = 1 and i_wb_valid held high: one retire per cycle. A new accept occurs on the cycle after count drops to 1, and the count sequence is 2, 1, 1, … with no record lost or duplicated (check by retire-order scoreboard).
- gwe = 0 for 3 cycles with valid and retire_en high: o_wb_ready = 0, o_count and all registers unchanged. Reads of a pending entry still return forwarded data.
- Record with regwe = 0, nzpwe = 1, data = 16'h8000: R[rd] unchanged, o_nzp = 100 while pending and after retire.
- Assert rst_n low mid-cycle with 2 pending entries: outputs go immediately to reset values, and no pending write reaches the register file.
